lfsr_stream: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator that packs successive feedback bits into OUT_W-bit words and delivers them over a valid/ready stream. Supersedes the fixed 8-bit free-running generator. Adds configurable width and taps, runtime seed loading with lock-up protection, step-enable gating from the clock divider, output backpressure, and a period-wrap marker. Sits between the clock divider's tick and LED/display or game-logic consumers.

---
 rtl/lfsr_stream_pkg.sv | 51 +++++
 rtl/lfsr_stream_if.sv | 23 ++
 rtl/lfsr_stream_step.sv | 14 +
 rtl/lfsr_stream.sv | 108 ++++++++++
 tb/tb_lfsr_stream.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_stream_pkg.sv
// Shared types and helpers for the LFSR stream generator family.
// Tap table entries are maximal-length masks, bit i = state[i] in the XOR.
package lfsr_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } out_state_t;

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  function automatic logic [31:0] LFSR_TAPS_DEFAULT(input int w);
    logic [31:0] t;
    case (w)
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_B400;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Seed-load and read-stream signals of the LFSR generator.
// The slave modport is the generator side, master is the consumer side.
interface lfsr_stream_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 8
);
  logic             seed_valid;
  logic [WIDTH-1:0] seed_data;
  logic             seed_ready;
  logic             rd_valid;
  logic             rd_ready;
  logic [OUT_W-1:0] rd_data;

  modport master (
    output seed_valid, seed_data, rd_ready,
    input  seed_ready, rd_valid, rd_data
  );

  modport slave (
    input  seed_valid, seed_data, rd_ready,
    output seed_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/lfsr_stream_step.sv
// Combinational Fibonacci LFSR step: feedback bit and shifted next state.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic [WIDTH-1:0] i_taps,
  output logic [WIDTH-1:0] o_next,
  output logic             o_fb
);
  assign o_fb   = parity(32'(i_state & i_taps));
  assign o_next = {i_state[WIDTH-2:0], o_fb};
endmodule

// File: rtl/lfsr_stream.sv
// LFSR generator packing feedback bits into OUT_W-bit words on a valid/ready
// stream, with seed loading, step gating, backpressure and a period-wrap pulse.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEFAULT(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               OUT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             step_en,
  lfsr_stream_if.slave     bus,
  output logic [WIDTH-1:0] lfsr_state,
  output logic             wrap
);

  localparam int             CW   = $clog2(OUT_W + 1);
  localparam logic [CW-1:0]  LAST = CW'(OUT_W - 1);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_stream: WIDTH out of range 4..32");
  end
  if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
    $fatal(1, "lfsr_stream: OUT_W out of range 1..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr_stream: SEED must be nonzero");
  end
  if (TAPS == '0) begin : g_bad_taps
    $fatal(1, "lfsr_stream: TAPS must be nonzero");
  end

  logic [WIDTH-1:0] r_state, r_ref, w_next, w_seed;
  logic [OUT_W-1:0] r_coll, r_data, w_word;
  logic [OUT_W:0]   w_shift;
  logic [CW-1:0]    r_cnt;
  logic             w_fb, w_load, w_stall, w_step, w_done, w_hs;
  logic             r_wrap;
  out_state_t       r_ost, w_ost_nxt;

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .i_state (r_state),
    .i_taps  (TAPS),
    .o_next  (w_next),
    .o_fb    (w_fb)
  );

  // The last bit of a word may only land once the output slot can take it.
  assign w_load  = bus.seed_valid;
  assign w_stall = (r_cnt == LAST) && (r_ost == VALID) && !bus.rd_ready;
  assign w_step  = step_en && !w_stall && !w_load;
  assign w_done  = w_step && (r_cnt == LAST);
  assign w_hs    = (r_ost == VALID) && bus.rd_ready;
  assign w_seed  = (bus.seed_data == '0) ? SEED : bus.seed_data;
  assign w_shift = {r_coll, w_fb};
  assign w_word  = w_shift[OUT_W-1:0];

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_ost <= EMPTY;
    else     r_ost <= w_ost_nxt;
  end

  always_comb begin
    w_ost_nxt = r_ost;
    case (r_ost)
      EMPTY:   if (w_done) w_ost_nxt = VALID;
      VALID:   if (w_done) w_ost_nxt = VALID;
               else if (w_hs) w_ost_nxt = EMPTY;
      default: w_ost_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
      r_ref   <= SEED;
      r_coll  <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_step && (w_next == r_ref);
      if (w_load) begin
        r_state <= w_seed;
        r_ref   <= w_seed;
        r_coll  <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_state <= w_next;
        r_coll  <= w_word;
        r_cnt   <= w_done ? '0 : r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)         r_data <= '0;
    else if (w_done) r_data <= w_word;
  end

  assign bus.seed_ready = ~rst;
  assign bus.rd_valid   = (r_ost == VALID);
  assign bus.rd_data    = r_data;
  assign lfsr_state     = r_state;
  assign wrap           = r_wrap;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: an 8-bit instance for stream/backpressure/seed
// behaviour and a 16-bit, 4-bit-word instance for the long period.
module tb_lfsr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, se_a, wrap_a;
  logic [7:0]  st_a;
  logic        rst_b, se_b, wrap_b;
  logic [15:0] st_b;

  lfsr_stream_if #(.WIDTH(8),  .OUT_W(8)) bus_a ();
  lfsr_stream_if #(.WIDTH(16), .OUT_W(4)) bus_b ();

  lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(8)) dut_a (
    .clk_in(clk), .rst(rst_a), .step_en(se_a), .bus(bus_a),
    .lfsr_state(st_a), .wrap(wrap_a)
  );

  lfsr_stream #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .OUT_W(4)) dut_b (
    .clk_in(clk), .rst(rst_b), .step_en(se_b), .bus(bus_b),
    .lfsr_state(st_b), .wrap(wrap_b)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] m_state, m_ref, m_coll;
  int         m_cnt;
  bit         m_valid;
  logic [7:0] q_a[$];

  task automatic model_reset();
    m_state = 8'h01; m_ref = 8'h01; m_coll = 8'h00; m_cnt = 0; m_valid = 0;
    q_a.delete();
  endtask

  // Drive one cycle on instance A and advance the reference model alongside.
  task automatic tick(input logic se, input logic rr, input logic sv, input logic [7:0] sd);
    logic fb, stall, step, hs;
    logic [7:0] nx;
    se_a = se; bus_a.rd_ready = rr; bus_a.seed_valid = sv; bus_a.seed_data = sd;
    stall = (m_cnt == 7) && m_valid && !rr;
    step  = se && !stall && !sv;
    hs    = m_valid && rr;
    fb    = ^(m_state & 8'hB8);
    nx    = {m_state[6:0], fb};
    if (hs) m_valid = 0;
    if (sv) begin
      m_state = (sd == 8'h00) ? 8'h01 : sd;
      m_ref = m_state; m_cnt = 0; m_coll = 8'h00;
    end else if (step) begin
      m_state = nx;
      m_coll  = {m_coll[6:0], fb};
      if (m_cnt == 7) begin
        m_cnt = 0; m_valid = 1; q_a.push_back(m_coll);
      end else m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1; se_a = 0; bus_a.rd_ready = 0; bus_a.seed_valid = 0; bus_a.seed_data = '0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    se_a = 0; bus_a.rd_ready = 0; bus_a.seed_valid = 0; bus_a.seed_data = '0;
    se_b = 0; bus_b.rd_ready = 0; bus_b.seed_valid = 0; bus_b.seed_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (st_a !== 8'h01) begin failures++; $display("FAIL reset_state got=%h exp=01", st_a); end
    checks++; if (bus_a.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_a.rd_valid); end
    checks++; if (bus_a.rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus_a.rd_data); end
    checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap_a); end
    checks++; if (bus_a.seed_ready !== 1'b0) begin failures++; $display("FAIL reset_seed_ready got=%b exp=0", bus_a.seed_ready); end
    rst_a = 1'b0;
    model_reset();
    #1;
    checks++; if (bus_a.seed_ready !== 1'b1) begin failures++; $display("FAIL seed_ready_after got=%b exp=1", bus_a.seed_ready); end
  endtask

  task automatic test_sequence();
    logic [7:0] tbl [8] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    reset_a();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus_a.rd_valid !== 1'b0) begin failures++; $display("FAIL seq_early_valid step=%0d got=%b exp=0", i, bus_a.rd_valid); end
      tick(1, 1, 0, 8'h00);
      checks++; if (st_a !== tbl[i]) begin failures++; $display("FAIL seq_state step=%0d got=%h exp=%h", i + 1, st_a, tbl[i]); end
    end
    checks++; if (bus_a.rd_valid !== 1'b1) begin failures++; $display("FAIL seq_valid got=%b exp=1", bus_a.rd_valid); end
    checks++; if (bus_a.rd_data !== 8'h1C) begin failures++; $display("FAIL seq_first_word got=%h exp=1C", bus_a.rd_data); end
  endtask

  task automatic test_wrap();
    int wraps = 0, first = -1, second = -1;
    logic [7:0] exp;
    reset_a();
    for (int k = 1; k <= 520; k++) begin
      if (bus_a.rd_valid) begin
        checks++;
        if (q_a.size() == 0) begin failures++; $display("FAIL wrap_pop unexpected word got=%h", bus_a.rd_data); end
        else begin
          exp = q_a.pop_front();
          if (bus_a.rd_data !== exp) begin failures++; $display("FAIL wrap_word got=%h exp=%h", bus_a.rd_data, exp); end
        end
      end
      tick(1, 1, 0, 8'h00);
      if (wrap_a === 1'b1) begin
        wraps++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
    end
    checks++; if (wraps !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", wraps); end
    checks++; if (first !== 255) begin failures++; $display("FAIL wrap_first got=%0d exp=255", first); end
    checks++; if (second !== 510) begin failures++; $display("FAIL wrap_second got=%0d exp=510", second); end
    checks++; if (st_a !== m_state) begin failures++; $display("FAIL wrap_end_state got=%h exp=%h", st_a, m_state); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    reset_a();
    repeat (8) tick(1, 1, 0, 8'h00);
    repeat (12) tick(1, 0, 0, 8'h00);
    checks++; if (st_a !== 8'h25) begin failures++; $display("FAIL bp_frozen_state got=%h exp=25", st_a); end
    checks++; if (bus_a.rd_data !== 8'h1C) begin failures++; $display("FAIL bp_held_word got=%h exp=1C", bus_a.rd_data); end
    checks++; if (bus_a.rd_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus_a.rd_valid); end
    checks++;
    if (!bus_a.rd_valid || q_a.size() == 0) begin failures++; $display("FAIL bp_pop no word valid=%b", bus_a.rd_valid); end
    else begin
      exp = q_a.pop_front();
      if (bus_a.rd_data !== exp) begin failures++; $display("FAIL bp_pop_word got=%h exp=%h", bus_a.rd_data, exp); end
    end
    tick(1, 1, 0, 8'h00);
    checks++; if (bus_a.rd_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%b exp=1", bus_a.rd_valid); end
    checks++; if (bus_a.rd_data !== 8'h4B) begin failures++; $display("FAIL bp_second_word got=%h exp=4B", bus_a.rd_data); end
    checks++; if (st_a !== 8'h4B) begin failures++; $display("FAIL bp_released_state got=%h exp=4B", st_a); end
  endtask

  task automatic test_seed_load();
    repeat (3) tick(1, 0, 0, 8'h00);
    tick(1, 0, 1, 8'h00);
    checks++; if (st_a !== 8'h01) begin failures++; $display("FAIL load_zero_state got=%h exp=01", st_a); end
    checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL load_zero_wrap got=%b exp=0", wrap_a); end
    checks++; if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== 8'h4B) begin failures++; $display("FAIL load_keeps_word got=%b/%h exp=1/4B", bus_a.rd_valid, bus_a.rd_data); end
    repeat (10) tick(1, 0, 0, 8'h00);
    checks++; if (st_a !== 8'h8E) begin failures++; $display("FAIL load_cnt_cleared got=%h exp=8E", st_a); end
    tick(0, 0, 1, 8'hA5);
    checks++; if (st_a !== 8'hA5) begin failures++; $display("FAIL load_a5 got=%h exp=A5", st_a); end
    tick(1, 0, 0, 8'h00);
    checks++; if (st_a !== 8'h4A) begin failures++; $display("FAIL step_after_a5 got=%h exp=4A", st_a); end
  endtask

  task automatic test_load_vs_step();
    logic [7:0] exp;
    tick(0, 0, 1, 8'h01);
    for (int k = 0; k < 254; k++) begin
      if (bus_a.rd_valid) begin
        checks++;
        if (q_a.size() == 0) begin failures++; $display("FAIL lvs_pop unexpected word got=%h", bus_a.rd_data); end
        else begin
          exp = q_a.pop_front();
          if (bus_a.rd_data !== exp) begin failures++; $display("FAIL lvs_word got=%h exp=%h", bus_a.rd_data, exp); end
        end
      end
      tick(1, 1, 0, 8'h00);
    end
    checks++; if (st_a !== 8'h80) begin failures++; $display("FAIL lvs_pred_state got=%h exp=80", st_a); end
    // The discarded step here would have returned to the reference value.
    tick(1, 0, 1, 8'h5A);
    checks++; if (st_a !== 8'h5A) begin failures++; $display("FAIL lvs_load_wins got=%h exp=5A", st_a); end
    checks++; if (wrap_a !== 1'b0) begin failures++; $display("FAIL lvs_no_wrap got=%b exp=0", wrap_a); end
  endtask

  task automatic test_async_reset();
    reset_a();
    repeat (10) tick(1, 0, 0, 8'h00);
    checks++; if (bus_a.rd_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1", bus_a.rd_valid); end
    #2 rst_a = 1'b1;
    #1;
    checks++; if (st_a !== 8'h01) begin failures++; $display("FAIL ar_state got=%h exp=01", st_a); end
    checks++; if (bus_a.rd_valid !== 1'b0 || bus_a.rd_data !== 8'h00) begin failures++; $display("FAIL ar_output got=%b/%h exp=0/00", bus_a.rd_valid, bus_a.rd_data); end
    checks++; if (wrap_a !== 1'b0 || bus_a.seed_ready !== 1'b0) begin failures++; $display("FAIL ar_flags got=%b/%b exp=0/0", wrap_a, bus_a.seed_ready); end
    @(posedge clk); #1;
    rst_a = 1'b0;
    model_reset();
  endtask

  task automatic test_w16();
    logic [15:0] ms;
    logic [3:0]  coll, exp;
    logic        fb;
    int cnt = 0, words = 0, bad = 0, wraps = 0, first = -1;
    logic [3:0]  qb[$];
    ms = 16'h0001; coll = 4'h0;
    se_b = 1'b1; bus_b.rd_ready = 1'b1;
    rst_b = 1'b0;
    for (int k = 1; k <= 65540; k++) begin
      if (bus_b.rd_valid) begin
        words++;
        if (qb.size() == 0) bad++;
        else begin
          exp = qb.pop_front();
          if (bus_b.rd_data !== exp) bad++;
        end
      end
      fb = ^(ms & 16'hB400);
      ms = {ms[14:0], fb};
      coll = {coll[2:0], fb};
      if (cnt == 3) begin cnt = 0; qb.push_back(coll); end else cnt++;
      @(posedge clk); #1;
      if (wrap_b === 1'b1) begin wraps++; if (first < 0) first = k; end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL w16_nibbles bad=%0d exp=0", bad); end
    checks++; if (words < 16000) begin failures++; $display("FAIL w16_word_count got=%0d exp>=16000", words); end
    checks++; if (first !== 65535) begin failures++; $display("FAIL w16_wrap_step got=%0d exp=65535", first); end
    checks++; if (wraps !== 1) begin failures++; $display("FAIL w16_wrap_count got=%0d exp=1", wraps); end
    checks++; if (st_b !== ms) begin failures++; $display("FAIL w16_state got=%h exp=%h", st_b, ms); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_backpressure();
    test_seed_load();
    test_load_vs_step();
    test_async_reset();
    test_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
